bconv_stream_layer: RTL and testbench

Parametrised streaming binary convolution layer. It generalises the fixed 28x28 / 3x3 / single-kernel BConv interface to configurable image size, kernel size and output-channel count. Pixels arrive one bit per cycle in raster order under a valid/ready handshake. Line buffers build a KxK window, and every output channel computes an XNOR-popcount against its own kernel, then a threshold compare. One N_CH-bit output word is produced per valid window position, under valid/ready with backpressure. Each channel's kernel and threshold are runtime-loadable.

---
 rtl/bconv_stream_layer.sv | 179 +++++++++++++++++
 tb/tb_bconv_stream_layer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bconv_stream_layer.sv
// Streaming binary convolution layer: KxK window over a raster bit stream,
// per-channel XNOR-popcount against a loadable kernel, then threshold compare.
module bconv_stream_layer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int N_CH  = 4,
    parameter int CNT_W = $clog2(K*K+1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [K*K-1:0]                           cfg_kernel,
    input  logic [CNT_W-1:0]                         cfg_thr,
    input  logic                                     pix_valid,
    output logic                                     pix_ready,
    input  logic                                     pix_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [N_CH-1:0]                          out_data,
    output logic                                     out_last,
    output logic                                     busy
);

    localparam int KK  = K * K;
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LBR = (K > 1) ? K - 1 : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t                state_q, state_d, pos_state;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [IMG_W-1:0]      lb_q [LBR];
    logic [IMG_W-1:0]      lb_d [LBR];
    logic [KK-1:0]         win_q, win_d, win_shift;
    logic [KK-1:0]         kern_q [N_CH];
    logic [KK-1:0]         kern_d [N_CH];
    logic [CNT_W-1:0]      thr_q [N_CH];
    logic [CNT_W-1:0]      thr_d [N_CH];
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [N_CH-1:0]       out_data_q, out_data_d;
    logic [N_CH-1:0]       res;
    logic [K-1:0]          colvec;
    logic                  accept, win_done, frame_end, cfg_hit, last_hs;

    function automatic logic [CNT_W-1:0] popcnt(input logic [KK-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < KK; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    assign accept    = pix_valid && pix_ready;
    assign win_done  = accept && (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
    assign frame_end = accept && (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
    assign last_hs   = out_valid_q && out_ready && out_last_q;
    assign cfg_hit   = cfg_we && (state_q == IDLE) && ({1'b0, cfg_ch} < (CHW+1)'(N_CH));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Column vector for the current column: oldest row at index 0, new pixel at K-1.
    always_comb begin
        int idx;
        lb_d      = lb_q;
        win_d     = win_q;
        win_shift = win_q >> 1;
        for (int r = 0; r < K; r++) begin
            idx       = (r < K - 1) ? (K - 2 - r) : 0;
            colvec[r] = (r == K - 1) ? pix_data : lb_q[idx][col_q];
        end
        if (accept) begin
            if (K > 1) begin
                lb_d[0][col_q] = pix_data;
                for (int j = 1; j < LBR; j++) begin
                    lb_d[j][col_q] = lb_q[j-1][col_q];
                end
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_d[r*K+c] = (c == K - 1) ? colvec[r] : win_shift[r*K+c];
                end
            end
        end
    end

    // A write landing with the first pixel of a frame is bypassed into that frame.
    always_comb begin
        kern_d = kern_q;
        thr_d  = thr_q;
        if (cfg_hit) begin
            kern_d[cfg_ch] = cfg_kernel;
            thr_d[cfg_ch]  = cfg_thr;
        end
        for (int i = 0; i < N_CH; i++) begin
            res[i] = (popcnt(~(win_d ^ kern_d[i])) >= thr_d[i]);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_last_d  = frame_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_comb begin
        pos_state = frame_end ? DRAIN : ((row_d >= RW'(K-1)) ? RUN : FILL);
        state_d   = state_q;
        case (state_q)
            IDLE, FILL, RUN: if (accept) state_d = pos_state;
            DRAIN:           if (last_hs) state_d = accept ? pos_state : IDLE;
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        pix_ready = !out_valid_q || out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int j = 0; j < LBR; j++) lb_q[j] <= '0;
            for (int i = 0; i < N_CH; i++) begin
                kern_q[i] <= '0;
                thr_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            lb_q        <= lb_d;
            kern_q      <= kern_d;
            thr_q       <= thr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bconv_stream_layer.sv
// Directed bench for bconv_stream_layer at default parameters (28x28, K=3, 4 channels).
module tb_bconv_stream_layer;

    logic       clk = 1'b0;
    logic       rst, cfg_we, pix_valid, pix_ready, pix_data;
    logic       out_valid, out_ready, out_last, busy;
    logic [1:0] cfg_ch;
    logic [8:0] cfg_kernel;
    logic [3:0] cfg_thr, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] bk [4];
    logic [3:0] bt [4];
    logic [3:0] obs_d [$];
    logic       obs_l [$];
    int         n_acc, stall_bad, busy_gaps, last_acc;
    bit         timed_out, stall_hit;
    logic [1:0] c_ch;
    logic [8:0] c_kern;
    logic [3:0] c_thr;

    always #5 clk = ~clk;

    bconv_stream_layer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_kernel(cfg_kernel),
        .cfg_thr(cfg_thr), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    function automatic logic pix(input int pat, input int r, input int c);
        case (pat)
            0:       return (c % 2 == 0);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (((r * 5 + c * 3 + r * c) % 7) < 3);
        endcase
    endfunction

    // Direct 2D reference: output n sits at window origin (n/26, n%26).
    function automatic logic [3:0] exp_word(input int pat, input int n);
        int orow = n / 26;
        int oc   = n % 26;
        logic [3:0] w = '0;
        for (int ch = 0; ch < 4; ch++) begin
            int m = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    if (pix(pat, orow + r, oc + c) == bk[ch][r*3+c]) m++;
            w[ch] = (m >= int'(bt[ch]));
        end
        return w;
    endfunction

    task automatic cfg_write(input logic [1:0] ch, input logic [8:0] k, input logic [3:0] t);
        cfg_we = 1'b1; cfg_ch = ch; cfg_kernel = k; cfg_thr = t;
        @(negedge clk);
        cfg_we = 1'b0;
        bk[ch] = k; bt[ch] = t;
    endtask

    task automatic set_std();
        cfg_write(2'd0, 9'h155, 4'd5);
        cfg_write(2'd1, 9'h0AA, 4'd5);
        cfg_write(2'd2, 9'h155, 4'd3);
        cfg_write(2'd3, 9'h000, 4'd0);
    endtask

    // Drives pixels and gathers consumed outputs; comparisons are made by the callers.
    task automatic collect(input int pat, input int nfr, input int mode, input int max_pix,
                           input int cfg_at, input int stall_at);
        int total, lim, cyc, stall_left, f;
        bit cfg_done, in_stall;
        logic ov, ol, bz, pr, ordy, pv;
        logic [3:0] od, held;
        total = nfr * 784;
        lim = (max_pix < total) ? max_pix : total;
        obs_d.delete(); obs_l.delete();
        n_acc = 0; stall_bad = 0; busy_gaps = 0; last_acc = 0; stall_hit = 0; timed_out = 0;
        cyc = 0; stall_left = 0; cfg_done = 0; held = '0;
        forever begin
            ov = out_valid; od = out_data; ol = out_last; bz = busy;
            if (n_acc >= lim && (lim < total || !ov)) break;
            if (cyc >= 30000) begin timed_out = 1; break; end
            in_stall = 0;
            if (mode == 0) begin
                if (stall_at >= 0 && !stall_hit && ov && obs_d.size() == stall_at) begin
                    stall_hit = 1; stall_left = 10; held = od;
                end
                if (stall_left > 0) begin
                    in_stall = 1; stall_left--;
                    if (!ov || od !== held) stall_bad++;
                end
                ordy = !in_stall;
                pv = (n_acc < lim);
            end else begin
                ordy = ($urandom_range(0, 2) != 0);
                pv = (n_acc < lim) && ($urandom_range(0, 2) != 0);
            end
            f = n_acc % 784;
            pix_valid = pv; pix_data = pix(pat, f / 28, f % 28); out_ready = ordy;
            cfg_we = (n_acc == cfg_at) && !cfg_done;
            if (cfg_we) begin
                cfg_done = 1; cfg_ch = c_ch; cfg_kernel = c_kern; cfg_thr = c_thr;
            end
            #1;
            pr = pix_ready;
            if (in_stall && pr) stall_bad++;
            if (n_acc > 0 && n_acc < total && !bz) busy_gaps++;
            if (ov && ordy) begin
                obs_d.push_back(od); obs_l.push_back(ol);
                if (ol && pv && pr) last_acc++;
            end
            if (pv && pr) n_acc++;
            @(negedge clk);
            cyc++;
        end
        pix_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready got %b want 1", pix_ready); end
    endtask

    task automatic test_stripes();
        set_std();
        collect(0, 1, 0, 784, -1, -1);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL stripes_timeout got 1 want 0"); end
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL stripes_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size() && n < 676; n++) begin
            n_tests++;
            if (obs_d[n] !== (((n % 26) % 2 == 0) ? 4'hD : 4'hE)) begin
                n_fail++; $display("FAIL stripes_data[%0d] got %h want %h", n, obs_d[n], ((n % 26) % 2 == 0) ? 4'hD : 4'hE);
            end
            n_tests++;
            if (obs_l[n] !== (n == 675)) begin n_fail++; $display("FAIL stripes_last[%0d] got %b want %b", n, obs_l[n], (n == 675)); end
        end
    endtask

    task automatic test_ones_zeros();
        for (int ch = 0; ch < 4; ch++) cfg_write(2'(ch), 9'h1FF, 4'd9);
        collect(1, 1, 0, 784, -1, -1);
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL ones_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size(); n++) begin
            n_tests++; if (obs_d[n] !== 4'hF) begin n_fail++; $display("FAIL ones_data[%0d] got %h want f", n, obs_d[n]); end
        end
        collect(2, 1, 0, 784, -1, -1);
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL zeros_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size(); n++) begin
            n_tests++; if (obs_d[n] !== 4'h0) begin n_fail++; $display("FAIL zeros_data[%0d] got %h want 0", n, obs_d[n]); end
        end
    endtask

    task automatic test_backpressure();
        set_std();
        collect(3, 1, 0, 784, -1, 30);
        n_tests++; if (stall_hit !== 1'b1) begin n_fail++; $display("FAIL bp_stall_seen got %b want 1", stall_hit); end
        n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stability got %0d violations want 0", stall_bad); end
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL bp_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size() && n < 676; n++) begin
            n_tests++; if (obs_d[n] !== exp_word(3, n)) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", n, obs_d[n], exp_word(3, n)); end
        end
    endtask

    task automatic test_random();
        cfg_write(2'd0, 9'h1B3, 4'd4);
        cfg_write(2'd1, 9'h05A, 4'd6);
        cfg_write(2'd2, 9'h1FF, 4'd7);
        cfg_write(2'd3, 9'h000, 4'd2);
        collect(3, 1, 1, 784, -1, -1);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL rand_timeout got 1 want 0"); end
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL rand_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size() && n < 676; n++) begin
            n_tests++; if (obs_d[n] !== exp_word(3, n)) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", n, obs_d[n], exp_word(3, n)); end
            n_tests++; if (obs_l[n] !== (n == 675)) begin n_fail++; $display("FAIL rand_last[%0d] got %b want %b", n, obs_l[n], (n == 675)); end
        end
    endtask

    task automatic test_reset_midframe();
        logic ov_before;
        for (int ch = 0; ch < 4; ch++) cfg_write(2'(ch), 9'h1FF, 4'd9);
        collect(2, 1, 0, 100, -1, -1);
        out_ready = 1'b0;
        ov_before = out_valid;
        rst = 1'b1;
        #1;
        n_tests++; if (ov_before !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", ov_before); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL mid_out_data got %h want 0", out_data); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL mid_out_last got %b want 0", out_last); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL mid_pix_ready got %b want 1", pix_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin bk[ch] = 9'h000; bt[ch] = 4'd0; end
        collect(2, 1, 0, 784, -1, -1);
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL cleared_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size(); n++) begin
            n_tests++; if (obs_d[n] !== 4'hF) begin n_fail++; $display("FAIL cleared_data[%0d] got %h want f", n, obs_d[n]); end
        end
        set_std();
        collect(3, 1, 0, 784, -1, -1);
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL recfg_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size() && n < 676; n++) begin
            n_tests++; if (obs_d[n] !== exp_word(3, n)) begin n_fail++; $display("FAIL recfg_data[%0d] got %h want %h", n, obs_d[n], exp_word(3, n)); end
        end
    endtask

    task automatic test_cfg_timing();
        set_std();
        c_ch = 2'd0; c_kern = 9'h0AA; c_thr = 4'd5;
        collect(0, 1, 0, 784, 200, -1);
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL cfgbusy_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size() && n < 676; n++) begin
            n_tests++;
            if (obs_d[n] !== (((n % 26) % 2 == 0) ? 4'hD : 4'hE)) begin
                n_fail++; $display("FAIL cfgbusy_data[%0d] got %h want %h", n, obs_d[n], ((n % 26) % 2 == 0) ? 4'hD : 4'hE);
            end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfgfirst_idle got %b want 0", busy); end
        collect(0, 1, 0, 784, 0, -1);
        bk[0] = 9'h0AA; bt[0] = 4'd5;
        n_tests++; if (obs_d.size() != 676) begin n_fail++; $display("FAIL cfgfirst_count got %0d want 676", obs_d.size()); end
        for (int n = 0; n < obs_d.size() && n < 676; n++) begin
            n_tests++;
            if (obs_d[n] !== (((n % 26) % 2 == 0) ? 4'hC : 4'hF)) begin
                n_fail++; $display("FAIL cfgfirst_data[%0d] got %h want %h", n, obs_d[n], ((n % 26) % 2 == 0) ? 4'hC : 4'hF);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_std();
        collect(3, 2, 0, 1568, -1, -1);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL b2b_timeout got 1 want 0"); end
        n_tests++; if (obs_d.size() != 1352) begin n_fail++; $display("FAIL b2b_count got %0d want 1352", obs_d.size()); end
        n_tests++; if (busy_gaps != 0) begin n_fail++; $display("FAIL b2b_busy_gap got %0d want 0", busy_gaps); end
        n_tests++; if (last_acc != 1) begin n_fail++; $display("FAIL b2b_last_with_pixel got %0d want 1", last_acc); end
        for (int n = 0; n < obs_d.size() && n < 1352; n++) begin
            n_tests++; if (obs_d[n] !== exp_word(3, n % 676)) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", n, obs_d[n], exp_word(3, n % 676)); end
            n_tests++; if (obs_l[n] !== (n % 676 == 675)) begin n_fail++; $display("FAIL b2b_last[%0d] got %b want %b", n, obs_l[n], (n % 676 == 675)); end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_kernel = '0; cfg_thr = '0;
        pix_valid = 1'b0; pix_data = 1'b0; out_ready = 1'b0;
        c_ch = '0; c_kern = '0; c_thr = '0;
        for (int ch = 0; ch < 4; ch++) begin bk[ch] = '0; bt[ch] = '0; end
        @(negedge clk);
        test_reset();
        test_stripes();
        test_ones_zeros();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_cfg_timing();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
